// File: rtl/out_fifo_8x4_sc_pkg.sv
// Shared types and constants for the transmit-direction PHY FIFO.
//   mode_e   : storage/drain organisation (two nibble beats per entry, or one)
//   phase_e  : which half of the current entry the next beat reads
//   entry_t  : one FIFO entry, one byte per channel
package out_fifo_pkg;

    typedef enum logic {MODE_8X4, MODE_4X4} mode_e;
    typedef enum logic {PH_LO, PH_HI} phase_e;

    localparam int NCH     = 10;
    localparam int NIB_W   = 4;
    localparam int BYTE_W  = 8;
    localparam int ENTRY_W = NCH * BYTE_W;
    localparam int CH5     = 5;
    localparam int CH6     = 6;

    typedef logic [NCH-1:0][BYTE_W-1:0] entry_t;

    // Channels 5 and 6 drain whole bytes; all others drain nibbles.
    function automatic bit is_byte_ch(int ch);
        return (ch == CH5) || (ch == CH6);
    endfunction

endpackage

// File: rtl/out_fifo_8x4_sc_if.sv
// Fabric/PHY bundle of the transmit FIFO.
//   wren, d[ch]   : push one byte per channel as one entry
//   rden          : pop one beat
//   q0-q4,q7-q9   : nibble per channel; q5,q6 : byte
//   empty/full/almostempty/almostfull : occupancy flags
// master = fabric/PHY side driving the FIFO, slave = the FIFO itself.
interface out_fifo_8x4_sc_if;
    import out_fifo_pkg::*;

    logic                          wren;
    logic [NCH-1:0][BYTE_W-1:0]    d;
    logic                          rden;
    logic [NIB_W-1:0]              q0, q1, q2, q3, q4, q7, q8, q9;
    logic [BYTE_W-1:0]             q5, q6;
    logic                          empty, full, almostempty, almostfull;

    modport master (
        output wren, d, rden,
        input  q0, q1, q2, q3, q4, q5, q6, q7, q8, q9,
        input  empty, full, almostempty, almostfull
    );

    modport slave (
        input  wren, d, rden,
        output q0, q1, q2, q3, q4, q5, q6, q7, q8, q9,
        output empty, full, almostempty, almostfull
    );

endinterface

// File: rtl/out_fifo_8x4_sc_occ_ctrl.sv
// Occupancy control: pointers, entry count, beat phase, accept logic, flags.
//   wren/rden           : raw requests
//   wr_acc/rd_acc       : accepted write / accepted beat this cycle
//   wr_ptr/rd_ptr       : storage indices (natural wrap)
//   phase               : PH_HI when the low half of rd_ptr's entry was already read
//   empty/full/almost*  : decoded from the registered count only
module fifo_occ_ctrl
    import out_fifo_pkg::*;
#(
    parameter int    DEPTH = 8,
    parameter int    AEV   = 1,
    parameter int    AFV   = 1,
    parameter mode_e MODE  = MODE_8X4,
    localparam int   PTR_W = $clog2(DEPTH),
    localparam int   CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren,
    input  logic             rden,
    output logic             wr_acc,
    output logic             rd_acc,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output phase_e           phase,
    output logic             empty,
    output logic             full,
    output logic             almostempty,
    output logic             almostfull
);

    logic [CNT_W-1:0] count;
    phase_e           phase_nxt;
    logic             pop;

    // A half-read entry still counts, so empty means no beat at all is left.
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign almostempty = (count <= CNT_W'(AEV));
    assign almostfull  = ((CNT_W'(DEPTH) - count) <= CNT_W'(AFV));

    // Pre-edge flags decide: a write at full is dropped even if a pop happens
    // in the same cycle, and a read at empty ignores a same-cycle write.
    assign wr_acc = wren & ~full;
    assign rd_acc = rden & ~empty;

    always_comb begin
        phase_nxt = phase;
        pop       = 1'b0;
        if (rd_acc) begin
            if (MODE == MODE_4X4) begin
                pop = 1'b1;
            end else begin
                case (phase)
                    PH_LO:   phase_nxt = PH_HI;
                    PH_HI: begin
                        phase_nxt = PH_LO;
                        pop       = 1'b1;
                    end
                    default: phase_nxt = PH_LO;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= PH_LO;
        else     phase <= phase_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_fifo_8x4_sc.sv
// Single-clock transmit PHY FIFO. The fabric writes a byte per channel per
// entry; the PHY drains each entry as low-nibble then high-nibble beats
// (ARRAY_MODE_8_X_4) or a single low-nibble beat (ARRAY_MODE_4_X_4).
// Channels 5/6 present the whole byte on every beat.
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : out_fifo_8x4_sc_if slave (write data/request, read request, Q, flags)
module out_fifo_8x4_sc
    import out_fifo_pkg::*;
#(
    parameter int DEPTH              = 8,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1,
    parameter     ARRAY_MODE         = "ARRAY_MODE_8_X_4"
) (
    input  logic               clk,
    input  logic               rst,
    out_fifo_8x4_sc_if.slave   bus
);

    localparam int    PTR_W = $clog2(DEPTH);
    localparam mode_e MODE  = (ARRAY_MODE == "ARRAY_MODE_4_X_4") ? MODE_4X4 : MODE_8X4;

    if (!(ARRAY_MODE == "ARRAY_MODE_8_X_4" || ARRAY_MODE == "ARRAY_MODE_4_X_4")) begin : g_bad_mode
        $fatal(1, "out_fifo_8x4_sc: unsupported ARRAY_MODE");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "out_fifo_8x4_sc: DEPTH must be a power of two >= 4");
    end
    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH - 1 ||
        ALMOST_FULL_VALUE  < 1 || ALMOST_FULL_VALUE  > DEPTH - 1) begin : g_bad_thr
        $fatal(1, "out_fifo_8x4_sc: almost thresholds out of range");
    end

    logic             wr_acc, rd_acc;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    phase_e           phase;
    logic             empty, full, almostempty, almostfull;

    fifo_occ_ctrl #(
        .DEPTH (DEPTH),
        .AEV   (ALMOST_EMPTY_VALUE),
        .AFV   (ALMOST_FULL_VALUE),
        .MODE  (MODE)
    ) u_occ (
        .clk         (clk),
        .rst         (rst),
        .wren        (bus.wren),
        .rden        (bus.rden),
        .wr_acc      (wr_acc),
        .rd_acc      (rd_acc),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .phase       (phase),
        .empty       (empty),
        .full        (full),
        .almostempty (almostempty),
        .almostfull  (almostfull)
    );

    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almostempty = almostempty;
    assign bus.almostfull  = almostfull;

    // Storage has no reset: after rst the pointers make old data unreachable.
    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.d;
    end

    entry_t rd_ent;
    logic   hi;

    assign rd_ent = mem[rd_ptr];
    assign hi     = (phase == PH_HI);

    // Q registers update only on an accepted beat; otherwise they hold.
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        if (is_byte_ch(ch)) begin : g_byte
            logic [BYTE_W-1:0] q_r;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         q_r <= '0;
                else if (rd_acc) q_r <= rd_ent[ch];
            end
        end else begin : g_nib
            logic [NIB_W-1:0] q_r;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         q_r <= '0;
                else if (rd_acc) q_r <= hi ? rd_ent[ch][7:4] : rd_ent[ch][3:0];
            end
        end
    end

    assign bus.q0 = g_ch[0].g_nib.q_r;
    assign bus.q1 = g_ch[1].g_nib.q_r;
    assign bus.q2 = g_ch[2].g_nib.q_r;
    assign bus.q3 = g_ch[3].g_nib.q_r;
    assign bus.q4 = g_ch[4].g_nib.q_r;
    assign bus.q5 = g_ch[5].g_byte.q_r;
    assign bus.q6 = g_ch[6].g_byte.q_r;
    assign bus.q7 = g_ch[7].g_nib.q_r;
    assign bus.q8 = g_ch[8].g_nib.q_r;
    assign bus.q9 = g_ch[9].g_nib.q_r;

endmodule
